// File: rtl/pipe_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready on both sides and a returned sideband tag.
// Optional feature: define PIPE_SHIFTER_ROTATE_EN to implement ROL/ROR; otherwise those ops pass in_a through.
module pipe_shifter #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_op,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag
);

    localparam int SHW   = $clog2(XLEN);
    localparam int SPLIT = SHW / 2;
    localparam int HIW   = SHW - SPLIT;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
`ifdef PIPE_SHIFTER_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    generate
        if (XLEN != 8 && XLEN != 16 && XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("pipe_shifter: XLEN must be 8, 16, 32 or 64");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers hold valid and payload until the transfer; ready may depend
    // combinationally on out_ready, never on in_valid.

    // One partial shift step. SRA fills from the sign captured at acceptance,
    // so a partial result whose MSB was shifted never leaks into the fill.
    function automatic logic [XLEN-1:0] shift_step(
        input logic [XLEN-1:0] v,
        input logic [2:0]      op,
        input logic [SHW-1:0]  amt,
        input logic            sign
    );
        logic [XLEN-1:0]   fill;
        logic [XLEN-1:0]   r;
`ifdef PIPE_SHIFTER_ROTATE_EN
        logic [2*XLEN-1:0] dbl;
        dbl = {v, v};
`endif
        fill = sign ? ~({XLEN{1'b1}} >> amt) : '0;
        case (op)
            OP_SLL: r = v << amt;
            OP_SRL: r = v >> amt;
            OP_SRA: r = (v >> amt) | fill;
`ifdef PIPE_SHIFTER_ROTATE_EN
            OP_ROL: begin
                dbl = dbl << amt;
                r   = dbl[2*XLEN-1:XLEN];
            end
            OP_ROR: begin
                dbl = dbl >> amt;
                r   = dbl[XLEN-1:0];
            end
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    // Stage 1 registers
    logic            s1_valid_q,  s1_valid_d;
    logic [XLEN-1:0] s1_data_q,   s1_data_d;
    logic [HIW-1:0]  s1_amt_q,    s1_amt_d;
    logic [2:0]      s1_op_q,     s1_op_d;
    logic [TAGW-1:0] s1_tag_q,    s1_tag_d;
    logic            s1_sign_q,   s1_sign_d;

    // Stage 2 (output) registers
    logic            out_valid_q,  out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [TAGW-1:0] out_tag_q,    out_tag_d;

    logic            s2_load;
    logic            s1_load;
    logic            in_fire;
    logic [SHW-1:0]  s1_amt_full;
    logic [SHW-1:0]  s2_amt_full;
    logic [XLEN-1:0] s1_partial;
    logic [XLEN-1:0] s2_final;

    logic unused_in_b;
    assign unused_in_b = &{1'b0, in_b[XLEN-1:SHW]};

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && s1_load;

    assign s1_amt_full = {{HIW{1'b0}}, in_b[SPLIT-1:0]};
    assign s2_amt_full = {s1_amt_q, {SPLIT{1'b0}}};
    assign s1_partial  = shift_step(in_a, in_op, s1_amt_full, in_a[XLEN-1]);
    assign s2_final    = shift_step(s1_data_q, s1_op_q, s2_amt_full, s1_sign_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_sign_d  = s1_sign_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
        end
        // Payload only changes on a real acceptance, so an idle stage keeps its last contents.
        if (in_fire) begin
            s1_data_d = s1_partial;
            s1_amt_d  = in_b[SHW-1:SPLIT];
            s1_op_d   = in_op;
            s1_tag_d  = in_tag;
            s1_sign_d = in_a[XLEN-1];
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = s2_final;
                out_tag_d    = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_amt_q     <= '0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s1_sign_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_amt_q     <= s1_amt_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s1_sign_q    <= s1_sign_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule
